// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: reads the 160x120 frame buffer in raster order and upscales each pixel 4x4.
// Optional build macro TEST_PATTERN_EN adds eight vertical colour bars selected by pattern_sel.
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   input  logic        pattern_sel,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        vga_clk,
   output logic        frame_start
);

   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic       r_pixEn;
   logic [9:0] r_hCnt;
   logic [9:0] r_vCnt;
   logic       r_hs;
   logic       r_vs;
   logic       r_blankN;
   logic [7:0] r_red;
   logic [7:0] r_green;
   logic [7:0] r_blue;
   logic       r_frameStart;
   logic       r_vgaClk;

   logic        w_visible;
   logic [14:0] w_vy;
   logic [14:0] w_hx;
   logic [2:0]  w_colour;

   // pix_en starts high so the first edge after reset already emits pixel (0,0).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pixEn <= 1'b1;
         r_hCnt  <= '0;
         r_vCnt  <= '0;
      end else begin
         r_pixEn <= ~r_pixEn;
         if (r_pixEn) begin
            if (r_hCnt == H_LAST) begin
               r_hCnt <= '0;
               r_vCnt <= (r_vCnt == V_LAST) ? 10'd0 : r_vCnt + 10'd1;
            end else begin
               r_hCnt <= r_hCnt + 10'd1;
            end
         end
      end
   end

   assign w_visible = (r_hCnt < H_VIS) && (r_vCnt < V_VIS);
   assign w_vy      = {7'd0, r_vCnt[9:2]};
   assign w_hx      = {7'd0, r_hCnt[9:2]};
   // y*160 as (y<<7)+(y<<5) avoids a multiplier.
   assign rd_addr   = w_visible ? (w_vy << 7) + (w_vy << 5) + w_hx : 15'd0;

`ifdef TEST_PATTERN_EN
   logic [2:0] w_bar;

   always_comb begin
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (r_hCnt >= 10'(k * (H_VISIBLE / 8))) begin
            w_bar = 3'(k);
         end
      end
   end

   assign w_colour = pattern_sel ? w_bar : rd_data;
`else
   // pattern_sel has no function without the pattern generator.
   logic w_unused;
   assign w_unused = pattern_sel;
   assign w_colour = rd_data;
`endif

   // Sync, blank and colour share this one stage so they stay aligned at the pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hs         <= 1'b1;
         r_vs         <= 1'b1;
         r_blankN     <= 1'b0;
         r_red        <= 8'h00;
         r_green      <= 8'h00;
         r_blue       <= 8'h00;
         r_frameStart <= 1'b0;
         r_vgaClk     <= 1'b0;
      end else begin
         r_vgaClk <= ~r_pixEn;
         if (r_pixEn) begin
            r_hs         <= ~((r_hCnt >= HS_START) && (r_hCnt < HS_END));
            r_vs         <= ~((r_vCnt >= VS_START) && (r_vCnt < VS_END));
            r_blankN     <= w_visible;
            r_red        <= (w_visible && w_colour[2]) ? 8'hFF : 8'h00;
            r_green      <= (w_visible && w_colour[1]) ? 8'hFF : 8'h00;
            r_blue       <= (w_visible && w_colour[0]) ? 8'hFF : 8'h00;
            r_frameStart <= (r_hCnt == 10'd0) && (r_vCnt == 10'd0);
         end else begin
            r_frameStart <= 1'b0;
         end
      end
   end

   assign vga_hs      = r_hs;
   assign vga_vs      = r_vs;
   assign vga_blank_n = r_blankN;
   assign vga_r       = r_red;
   assign vga_g       = r_green;
   assign vga_b       = r_blue;
   assign frame_start = r_frameStart;
   assign vga_clk     = r_vgaClk;
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken timing so whole frames fit in a short run.
// A pixel-index reference model queues expected pins; a monitor pops and compares each pixel period.
module tb_vga_scanout;

   localparam int HV  = 32;
   localparam int HFP = 4;
   localparam int HSY = 8;
   localparam int HBP = 4;
   localparam int VV  = 16;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int HT  = HV + HFP + HSY + HBP;
   localparam int VT  = VV + VFP + VSY + VBP;
   localparam int PIX_FRAME = HT * VT;
   localparam int FRAME_CLK = 2 * PIX_FRAME;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       blank;
      logic       fs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } expT;

   logic        clk;
   logic        reset_n;
   logic [14:0] rd_addr;
   logic [2:0]  rd_data;
   logic        pattern_sel;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        vga_sync_n;
   logic        vga_clk;
   logic        frame_start;

   logic [2:0] fb [0:32767];
   expT        expQ [$];
   expT        cur;
   int         cyc;
   int         fsSeen;
   int         nAssert;
   int         nFail;

   vga_scanout #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .pattern_sel(pattern_sel),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .vga_hs(vga_hs),
      .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n),
      .vga_clk(vga_clk),
      .frame_start(frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Frame buffer with a one-clock synchronous read port
   always @(posedge clk) begin
      rd_data <= fb[rd_addr];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nAssert++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   function automatic int addrOf(input int m);
      int h;
      int v;
      h = m % HT;
      v = m / HT;
      return ((h < HV) && (v < VV)) ? (v / 4) * 160 + h / 4 : 0;
   endfunction

   function automatic expT expectPixel(input int n);
      int         h;
      int         v;
      logic [2:0] c;
      expT        e;
      h       = n % HT;
      v       = n / HT;
      e.blank = (h < HV) && (v < VV);
      e.hs    = !((h >= HV + HFP) && (h < HV + HFP + HSY));
      e.vs    = !((v >= VV + VFP) && (v < VV + VFP + VSY));
      c       = e.blank ? fb[(v / 4) * 160 + h / 4] : 3'd0;
`ifdef TEST_PATTERN_EN
      if (pattern_sel) c = 3'(h / (HV / 8));
`endif
      e.r  = (e.blank && c[2]) ? 8'hFF : 8'h00;
      e.g  = (e.blank && c[1]) ? 8'hFF : 8'h00;
      e.b  = (e.blank && c[0]) ? 8'hFF : 8'h00;
      e.fs = (n == 0);
      return e;
   endfunction

   // Reference model: every other clock after reset release is one pixel, numbered from frame start.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc = 0;
         expQ.delete();
      end else begin
         cyc = cyc + 1;
         if (cyc % 2 == 1) begin
            expQ.push_back(expectPixel(((cyc - 1) / 2) % PIX_FRAME));
         end
      end
   end

   // Monitor: new pixel on odd cycles, held values on even cycles.
   always @(negedge clk) begin
      if (reset_n && cyc > 0) begin
         checkOutput("vga_clk", int'(vga_clk), int'(cyc % 2 == 0));
         checkOutput("vga_sync_n", int'(vga_sync_n), 0);
         checkOutput("rd_addr", int'(rd_addr), addrOf(((cyc + 1) / 2) % PIX_FRAME));
         if (cyc % 2 == 1) begin
            if (expQ.size() == 0) begin
               checkOutput("queue_empty", 0, 1);
            end else begin
               cur = expQ.pop_front();
               checkOutput("frame_start", int'(frame_start), int'(cur.fs));
            end
         end else begin
            checkOutput("frame_start_clear", int'(frame_start), 0);
         end
         checkOutput("vga_hs", int'(vga_hs), int'(cur.hs));
         checkOutput("vga_vs", int'(vga_vs), int'(cur.vs));
         checkOutput("vga_blank_n", int'(vga_blank_n), int'(cur.blank));
         checkOutput("vga_r", int'(vga_r), int'(cur.r));
         checkOutput("vga_g", int'(vga_g), int'(cur.g));
         checkOutput("vga_b", int'(vga_b), int'(cur.b));
         if (frame_start) begin
            fsSeen++;
            checkOutput("fs_spacing", (cyc - 1) % FRAME_CLK, 0);
         end
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_hs"}, int'(vga_hs), 1);
      checkOutput({tag, "_vs"}, int'(vga_vs), 1);
      checkOutput({tag, "_blank_n"}, int'(vga_blank_n), 0);
      checkOutput({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
      checkOutput({tag, "_frame_start"}, int'(frame_start), 0);
      checkOutput({tag, "_vga_clk"}, int'(vga_clk), 0);
      checkOutput({tag, "_sync_n"}, int'(vga_sync_n), 0);
      checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
   endtask

   // Runs clocks while randomly toggling pattern_sel, which the default build must ignore.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) pattern_sel = ~pattern_sel;
      end
   endtask

   initial begin
      nAssert     = 0;
      nFail       = 0;
      fsSeen      = 0;
      cur         = '0;
      reset_n     = 1'b0;
      pattern_sel = 1'b0;
      for (int i = 0; i < 32768; i++) fb[i] = 3'($urandom_range(0, 7));
      fb[0] = 3'b100;
      fb[1] = 3'b010;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("reset");
      reset_n = 1'b1;

      applyStimulus(3 * FRAME_CLK);
      checkOutput("frame_count_1", fsSeen, 3);

      applyStimulus($urandom_range(200, 1500));
      for (int i = 0; i < 200 && !vga_blank_n; i++) @(negedge clk);
      checkOutput("visible_before_reset", int'(vga_blank_n), 1);
      #3;
      reset_n = 1'b0;
      #1;
      checkResetState("async_reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("held_reset");
      fsSeen  = 0;
      reset_n = 1'b1;

      applyStimulus(2 * FRAME_CLK);
      checkOutput("frame_count_2", fsSeen, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
